// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the packet-granular stream arbiter.
package stream_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEFAULT_DATA_W = 8;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping to 0.
module rr_pick #(
    parameter int N_IN  = 4,
    parameter int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk the requests in priority order starting at ptr; the first hit wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N_IN; k++) begin
            j = (int'(ptr) + k) % N_IN;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// N-input packet round-robin arbiter with a registered output stage.
// Optional per-input completed-packet counters: define STREAM_PKT_ARB_CNT_EN.
module stream_pkt_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN-1:0]          in_last,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    output logic [N_IN-1:0]          in_ready,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_idx
`ifdef STREAM_PKT_ARB_CNT_EN
    ,
    output logic [N_IN*CNT_W-1:0]    pkt_cnt
`endif
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                sel_valid, sel_last;
    logic [DATA_W-1:0]   sel_data;
    logic                out_free;
    logic                in_xfer;

    rr_pick #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Route the currently granted input's beat to the output stage.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign out_free = !out_valid_q || out_ready;
    assign in_xfer  = (state_q == GRANT) && sel_valid && out_free;

    // Next-state logic and the per-input ready decode (never depends on in_valid).
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        in_ready = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < N_IN; i++) begin
                    if (grant_q == IDX_W'(i)) in_ready[i] = out_free;
                end
                if (in_xfer && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(N_IN - 1)) ? '0 : grant_q + 1'b1;
                end
            end
        endcase
    end

    // Output holding register: load on input transfer, empty on drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_last_d  = sel_last;
            out_data_d  = sel_data;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == GRANT);
    assign grant_idx = grant_q;

`ifdef STREAM_PKT_ARB_CNT_EN
    logic [N_IN*CNT_W-1:0] cnt_q, cnt_d;

    // Bump the granted input's counter when its last beat is accepted.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_IN; i++) begin
            if (in_xfer && sel_last && (grant_q == IDX_W'(i))) begin
                cnt_d[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end

    // Packet counters, cleared by reset, wrap naturally at CNT_W bits.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Self-checking bench for stream_pkt_arbiter (N_IN=4, DATA_W=8).
module tb_stream_pkt_arbiter;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid, in_last, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_last, out_ready, busy;
    logic [7:0]  out_data;
    logic [1:0]  grant_idx;
`ifdef STREAM_PKT_ARB_CNT_EN
    logic [N*16-1:0] pkt_cnt;
`endif

    stream_pkt_arbiter #(.N_IN(N), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .grant_idx (grant_idx)
`ifdef STREAM_PKT_ARB_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "timeout");
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (spec-level, integer based) ----------------
    bit         m_busy = 0;
    int         m_gnt = 0, m_ptr = 0;
    bit         m_ov = 0, m_ol = 0;
    logic [7:0] m_od = 8'h00;
    bit         use_model = 0;

    logic [3:0] xfer, rdy_seen;
    int         out_beats = 0;
    logic [8:0] sbq[$];

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        r = 4'b0;
        if (m_busy && (!m_ov || out_ready)) r[m_gnt] = 1'b1;
        return r;
    endfunction

    // One clock: check DUT against model, scoreboard beats, advance the model.
    task automatic tick();
        logic [3:0] er;
        bit nb, nov, nol;
        int ng, np;
        logic [7:0] nod;
        logic [8:0] exp_beat;
        #1;
        rdy_seen = in_ready;
        xfer     = in_valid & in_ready;
        er       = m_ready();
        if (use_model) begin
            chk("mdl_in_ready", in_ready, er);
            chk("mdl_out_valid", out_valid, m_ov);
            chk("mdl_busy", busy, m_busy);
            chk("mdl_grant_idx", grant_idx, m_gnt);
            if (m_ov) begin
                chk("mdl_out_data", out_data, m_od);
                chk("mdl_out_last", out_last, m_ol);
            end
        end
        if (!rst_n) begin
            sbq.delete();
        end else if (use_model) begin
            if (out_valid && out_ready) begin
                out_beats++;
                if (sbq.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL sb_extra: got beat 0x%0h, want no beat", {out_last, out_data});
                end else begin
                    exp_beat = sbq.pop_front();
                    chk("sb_beat", {out_last, out_data}, exp_beat);
                end
            end
            for (int i = 0; i < N; i++)
                if (xfer[i]) sbq.push_back({in_last[i], in_data[i*8 +: 8]});
        end
        nb = m_busy; ng = m_gnt; np = m_ptr; nov = m_ov; nol = m_ol; nod = m_od;
        if (!rst_n) begin
            nb = 0; ng = 0; np = 0; nov = 0; nol = 0; nod = 8'h00;
        end else if (!m_busy) begin
            for (int k = N - 1; k >= 0; k--)
                if (in_valid[(m_ptr + k) % N]) begin nb = 1; ng = (m_ptr + k) % N; end
            if (m_ov && out_ready) nov = 0;
        end else begin
            if (er[m_gnt] && in_valid[m_gnt]) begin
                nov = 1; nol = in_last[m_gnt]; nod = in_data[m_gnt*8 +: 8];
                if (in_last[m_gnt]) begin nb = 0; np = (m_gnt + 1) % N; end
            end else if (m_ov && out_ready) begin
                nov = 0;
            end
        end
        @(posedge clk);
        m_busy = nb; m_gnt = ng; m_ptr = np; m_ov = nov; m_ol = nol; m_od = nod;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 4'h0; in_last = 4'h0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst; logic [3:0] v; logic [3:0] l; logic [31:0] d; bit ordy; bit chk;
        logic [3:0] e_rdy; bit e_ov; bit e_ol; logic [7:0] e_od; bit e_busy; logic [1:0] e_g;
    } vec_t;
    vec_t tv[$];

    task automatic add(input bit r, input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input bit c, input logic [3:0] er, input bit eov, input bit eol,
                       input logic [7:0] eod, input bit eb, input logic [1:0] eg);
        tv.push_back('{r, v, l, d, 1'b1, c, er, eov, eol, eod, eb, eg});
    endtask

    initial begin
        int k, gap, pk, ng, idle_run, ob0;
        bit done0, sent3, prev_busy;
        int gseq[5];
        int exp_rr[5];
        logic [7:0] frozen;
        logic [3:0] sv, sl;
        logic [7:0] sd[4];
        int bc[4];

        //   rst  valid last  data           chk rdy   ov ol od     busy g
        add(0, 4'h0, 4'h0, 32'h0000_0000, 0, 4'h0, 0, 0, 8'h00, 0, 0);
        add(1, 4'h2, 4'h0, 32'h0000_1100, 1, 4'h0, 0, 0, 8'h00, 0, 0);
        add(1, 4'h2, 4'h0, 32'h0000_1100, 1, 4'h2, 0, 0, 8'h00, 1, 1);
        add(1, 4'h2, 4'h0, 32'h0000_2200, 1, 4'h2, 1, 0, 8'h11, 1, 1);
        add(1, 4'h2, 4'h2, 32'h0000_3300, 1, 4'h2, 1, 0, 8'h22, 1, 1);
        add(1, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 1, 1, 8'h33, 0, 1);
        add(1, 4'h8, 4'h8, 32'hAA00_0000, 1, 4'h0, 0, 0, 8'h00, 0, 1);
        add(1, 4'h8, 4'h8, 32'hAA00_0000, 1, 4'h8, 0, 0, 8'h00, 1, 3);
        add(1, 4'hA, 4'hA, 32'hBB00_CC00, 1, 4'h0, 1, 1, 8'hAA, 0, 3);
        add(1, 4'hA, 4'hA, 32'hBB00_CC00, 1, 4'h2, 0, 0, 8'h00, 1, 1);
        add(1, 4'h8, 4'h8, 32'hBB00_0000, 1, 4'h0, 1, 1, 8'hCC, 0, 1);
        add(1, 4'h8, 4'h8, 32'hBB00_0000, 1, 4'h8, 0, 0, 8'h00, 1, 3);
        add(1, 4'h0, 4'h0, 32'h0000_0000, 1, 4'h0, 1, 1, 8'hBB, 0, 3);

        rst_n = 1'b0; in_valid = 4'h0; in_last = 4'h0; in_data = 32'h0; out_ready = 1'b1;
        @(negedge clk);
        foreach (tv[t]) begin
            rst_n = tv[t].rst; in_valid = tv[t].v; in_last = tv[t].l;
            in_data = tv[t].d; out_ready = tv[t].ordy;
            #1;
            if (tv[t].chk) begin
                chk($sformatf("tbl_in_ready[%0d]", t), in_ready, tv[t].e_rdy);
                chk($sformatf("tbl_out_valid[%0d]", t), out_valid, tv[t].e_ov);
                chk($sformatf("tbl_busy[%0d]", t), busy, tv[t].e_busy);
                chk($sformatf("tbl_grant_idx[%0d]", t), grant_idx, tv[t].e_g);
                if (tv[t].e_ov) begin
                    chk($sformatf("tbl_out_data[%0d]", t), out_data, tv[t].e_od);
                    chk($sformatf("tbl_out_last[%0d]", t), out_last, tv[t].e_ol);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end

        use_model = 0;
        do_reset();
        use_model = 1;

        // Reset mid-packet: input 2 granted, 3 beats sent, then reset.
        k = 0;
        for (int c = 0; c < 10 && k < 3; c++) begin
            in_valid = 4'h4; in_last = 4'h0; in_data = {8'h0, 8'(8'h60 + k), 16'h0};
            tick();
            if (xfer[2]) k++;
        end
        chk("rst_beats_sent", k, 3);
        rst_n = 1'b0; in_valid = 4'h5;
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        tick();
        chk("rst_winner_busy", busy, 1);
        chk("rst_winner_idx", grant_idx, 0);
        do_reset();

        // Round robin: all inputs valid, 2-beat packets.
        exp_rr = '{0, 1, 2, 3, 0};
        gseq = '{default: -1};
        bc = '{default: 0};
        ng = 0; idle_run = 0; prev_busy = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            in_valid = 4'hF;
            for (int i = 0; i < N; i++) begin
                in_last[i] = bc[i][0];
                in_data[i*8 +: 8] = 8'((i << 4) + bc[i]);
            end
            tick();
            for (int i = 0; i < N; i++) if (xfer[i]) bc[i]++;
            if (busy && !prev_busy) begin
                if (ng > 0) chk("rr_idle_gap", idle_run, 1);
                gseq[ng] = grant_idx;
                ng++;
                idle_run = 0;
            end
            if (!busy) idle_run++;
            prev_busy = busy;
        end
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order[%0d]", i), gseq[i], exp_rr[i]);
        do_reset();

        // Back-pressure: out_ready low for 5 cycles in the middle of a 6-beat packet.
        k = 0; ob0 = out_beats; frozen = 8'h00;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 4 && c < 9);
            in_valid  = (k < 6) ? 4'h2 : 4'h0;
            in_last   = (k == 5) ? 4'h2 : 4'h0;
            in_data   = {16'h0, 8'(8'h50 + k), 8'h0};
            tick();
            if (c >= 4 && c < 9) chk("bp_in_ready_held", rdy_seen[1], 0);
            if (xfer[1]) k++;
            if (c == 3) frozen = out_data;
            if (c >= 4 && c <= 8) chk("bp_out_frozen", out_data, frozen);
        end
        chk("bp_beats_sent", k, 6);
        chk("bp_beats_out", out_beats - ob0, 6);
        out_ready = 1'b1;
        do_reset();

        // No interleave: input 3 waits while input 0 pauses mid-packet.
        k = 0; gap = 0; done0 = 0; sent3 = 0;
        for (int c = 0; c < 25; c++) begin
            in_valid[0] = (k < 3);
            if (k == 1 && gap < 2) begin in_valid[0] = 1'b0; gap++; end
            in_valid[3] = !sent3; in_valid[2:1] = 2'b00;
            in_last = {1'b1, 2'b00, (k == 2)};
            in_data = {8'hD3, 16'h0, 8'(8'hA0 + k)};
            tick();
            if (!done0) chk("ni_in_ready3", rdy_seen[3], 0);
            if (xfer[0]) begin if (k == 2) done0 = 1; k++; end
            if (xfer[3]) sent3 = 1;
        end
        chk("ni_done0", done0, 1);
        chk("ni_served3", sent3, 1);
        do_reset();

`ifdef STREAM_PKT_ARB_CNT_EN
        // Counters: three 2-beat packets on input 2.
        pk = 0; k = 0;
        for (int c = 0; c < 40 && pk < 3; c++) begin
            in_valid = 4'h4; in_last = (k % 2 == 1) ? 4'h4 : 4'h0;
            in_data = {8'h0, 8'(8'h70 + k), 16'h0};
            tick();
            if (xfer[2]) begin if (k % 2 == 1) pk++; k++; end
        end
        in_valid = 4'h0;
        tick();
        for (int i = 0; i < N; i++)
            chk($sformatf("cnt_slice[%0d]", i), pkt_cnt[i*16 +: 16], (i == 2) ? 3 : 0);
        do_reset();
`endif

        // Random traffic against the model and the beat scoreboard.
        for (int i = 0; i < N; i++) begin
            sv[i] = 1'b0; sl[i] = 1'b0; sd[i] = 8'h00;
        end
        for (int c = 0; c < 3000; c++) begin
            in_valid = sv; in_last = sl;
            in_data = {sd[3], sd[2], sd[1], sd[0]};
            out_ready = ($urandom % 4) != 0;
            rst_n = ($urandom % 700) != 0;
            tick();
            for (int i = 0; i < N; i++) begin
                if (xfer[i] || !sv[i]) begin
                    sv[i] = ($urandom % 3) != 0;
                    sd[i] = 8'($urandom);
                    sl[i] = ($urandom % 3) == 0;
                end
            end
        end
        rst_n = 1'b1; in_valid = 4'h0; in_last = 4'h0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("sb_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/stream_pkt_arbiter.md
Name: stream_pkt_arbiter

Overview:
- N-input, packet-granular round-robin arbiter for 8-bit valid/last/data streams.
- Once granted, an input keeps the output until its `last` beat transfers; packets are never interleaved.
- Replaces ad-hoc two-way select toggling in front of downstream stream consumers.
- Output is fully registered, with standard valid/ready back-pressure.

Parameters:
- N_IN, 4, number of input streams (2..16).
- DATA_W, 8, stream data width.
- IDX_W, $clog2(N_IN) (min 1), width of the grant index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  N_IN  per-input beat valid.
- in_last  in  N_IN  per-input end-of-packet flag.
- in_data  in  N_IN*DATA_W  flattened data; input i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  N_IN  per-input ready.
- out_valid  out  1  registered output beat valid.
- out_last  out  1  registered end-of-packet flag.
- out_data  out  DATA_W  registered output data.
- out_ready  in  1  downstream ready.
- busy  out  1  high while in GRANT state.
- grant_idx  out  IDX_W  index of the currently granted input; holds its last value in IDLE.

Behaviour:
- Handshake rules:
  - Input beat i transfers when in_valid[i] && in_ready[i].
  - Output beat transfers when out_valid && out_ready.
  - in_valid may be held or dropped mid-packet. Gaps are legal; the grant stays until `last`.
- Reset (synchronous, active-low, overrides all other activity):
  - Registers: state=IDLE, rr_ptr=0, grant_idx=0, out_valid=0, out_last=0, out_data=0, in_ready=0.
  - Reset mid-packet discards the packet silently.
- State machine:
  - IDLE:
    - Scan in_valid starting at rr_ptr, wrapping modulo N_IN.
    - First set bit found: latch grant_idx, go to GRANT.
    - No valid bits: stay in IDLE.
    - in_ready is all-zero in IDLE.
  - GRANT:
    - in_ready[grant_idx] = (!out_valid || out_ready); all other in_ready bits are 0.
    - in_ready is combinational from state, grant_idx, out_valid and out_ready only, never from in_valid.
    - On an input transfer: out_data/out_last load from the granted input and out_valid becomes 1.
    - On an output transfer with no new input transfer: out_valid becomes 0.
    - On an input transfer with in_last=1: rr_ptr becomes (grant_idx+1) mod N_IN, next state is IDLE.
- Latency:
  - Valid seen in IDLE at cycle 0; in_ready high at cycle 1.
  - The first beat appears on out_* at cycle 2 if it transferred at cycle 1.
  - One bubble cycle (IDLE) follows every packet.
- Throughput:
  - One beat per cycle within a packet while out_ready=1.
  - With out_ready low, exactly one beat is held in the output register.
- Boundary conditions:
  - Single-beat packet (valid & last together): GRANT lasts one cycle.
  - All inputs valid: service order is rr_ptr, rr_ptr+1, ... (wrap); no input is starved.
  - rr_ptr = N_IN-1 wraps to 0.
  - out_data/out_last are stable while out_valid && !out_ready.

Optional Feature:
- Macro: STREAM_PKT_ARB_CNT_EN.
- When defined, adds output `pkt_cnt`, width N_IN*16, flattened with the same indexing as in_data.
  - Counter i increments on each input transfer from i with in_last=1.
  - Counters wrap at 16 bits and reset to 0.
- When undefined, the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package stream_arb_pkg: state enum (IDLE, GRANT); DEFAULT_DATA_W=8; counter width constant CNT_W=16.
- Sub-module rr_pick, purely combinational:
  - Inputs: req[N_IN], ptr[IDX_W].
  - Outputs: found, idx[IDX_W].
  - Selects the first set bit at or after ptr, with wrap-around.

Test Plan:
- Reset mid-packet:
  - Stimulus: grant input 2, send 3 beats, assert rst_n=0 for 1 cycle.
  - Required: next cycle out_valid=0, busy=0, in_ready=0, rr_ptr=0; input 0 wins next if valid.
- Single requester:
  - Stimulus: input 1 sends packet 0x11,0x22,0x33 (last on 0x33), out_ready=1.
  - Required: in_ready[1] rises at cycle 1; out_data shows 0x11/0x22/0x33 on cycles 2-4; out_last only with 0x33.
- Round-robin:
  - Stimulus: all 4 inputs continuously valid with 2-beat packets, starting rr_ptr=0.
  - Required: grant_idx sequence 0,1,2,3,0 with one IDLE cycle between packets.
- Back-pressure:
  - Stimulus: out_ready held 0 for 5 cycles mid-packet.
  - Required: out_data frozen; in_ready[grant_idx]=0 while out_valid=1; no beat lost or duplicated after release.
- No interleave:
  - Stimulus: input 3 valid while input 0 holds the grant with a 2-cycle in_valid gap.
  - Required: in_ready[3] stays 0 until input 0's last transfers.
- Counters (STREAM_PKT_ARB_CNT_EN defined):
  - Stimulus: 3 packets on input 2.
  - Required: pkt_cnt slice 2 = 3; all other slices = 0.
